vcu_timer_bank: RTL and testbench

- Multi-channel countdown timer peripheral on the CPU's VCU register port (control/wdata write strobes, rdata read).
- Generalises the single fixed-reload tick counter: NUM_CH independent channels, programmable reload, one-shot or periodic mode, pause/resume, sticky done flags.
- Status bit 0 of rdata keeps its existing meaning ("timer 0 expired"), so current polling firmware runs unchanged.

---
 rtl/vcu_timer_pkg.sv | 26 ++
 rtl/vcu_timer_bank_if.sv | 18 +
 rtl/vcu_timer_ch.sv | 96 +++++++++
 rtl/vcu_timer_bank.sv | 100 ++++++++++
 tb/tb_vcu_timer_bank.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/vcu_timer_pkg.sv
// Shared definitions for the VCU timer bank: control word layout, read selector and channel states.
package vcu_timer_pkg;

    localparam int SEL_LSB      = 0;
    localparam int SEL_MSB      = 3;
    localparam int PERIODIC_BIT = 8;
    localparam int ENABLE_BIT   = 9;
    localparam int CLR_BIT      = 10;
    localparam int RSEL_LSB     = 12;
    localparam int RSEL_MSB     = 13;
    localparam int SEL_W        = SEL_MSB - SEL_LSB + 1;

    typedef enum logic [1:0] {
        RS_STATUS = 2'd0,
        RS_COUNT  = 2'd1,
        RS_RELOAD = 2'd2,
        RS_STATE  = 2'd3
    } rsel_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } tmr_state_e;

endpackage

// File: rtl/vcu_timer_bank_if.sv
// VCU register port: control/wdata write strobes from the CPU, rdata back.
interface vcu_timer_bank_if;
    logic [31:0] vcu_reg_control;
    logic        vcu_reg_control_we;
    logic [31:0] vcu_reg_wdata;
    logic        vcu_reg_wdata_we;
    logic [31:0] vcu_reg_rdata;

    modport master (
        output vcu_reg_control, vcu_reg_control_we, vcu_reg_wdata, vcu_reg_wdata_we,
        input  vcu_reg_rdata
    );

    modport slave (
        input  vcu_reg_control, vcu_reg_control_we, vcu_reg_wdata, vcu_reg_wdata_we,
        output vcu_reg_rdata
    );
endinterface

// File: rtl/vcu_timer_ch.sv
// One countdown channel: IDLE/RUN/DONE with one-shot or periodic reload and a sticky done flag.
module vcu_timer_ch
    import vcu_timer_pkg::*;
#(
    parameter int               CNT_W      = 28,
    parameter logic [CNT_W-1:0] RST_RELOAD = '0
) (
    input  logic             clk,
    input  logic             reset_p,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             pause,
    input  logic             resume,
    input  logic             set_mode,
    input  logic             mode_in,
    input  logic             clr_done,
    output logic [CNT_W-1:0] count_o,
    output logic [CNT_W-1:0] reload_o,
    output tmr_state_e       state_o,
    output logic             mode_o,
    output logic             done_o,
    output logic             tick_o
);

    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] reload_q, reload_d;
    tmr_state_e       state_q, state_d;
    logic             mode_q, mode_d;
    logic             done_q, done_d;
    logic             tick_q, tick_d;

    always_comb begin
        count_d  = count_q;
        reload_d = reload_q;
        state_d  = state_q;
        mode_d   = mode_q;
        done_d   = done_q;
        tick_d   = 1'b0;

        if (set_mode) mode_d = mode_in;
        // Clear is applied before expiry so a coincident expiry leaves done set.
        if (clr_done) done_d = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (pause) begin
                    state_d = ST_IDLE;
                end else if (count_q == '0) begin
                    done_d = 1'b1;
                    tick_d = 1'b1;
                    if (mode_q) count_d = reload_q;
                    else        state_d = ST_DONE;
                end else begin
                    count_d = count_q - CNT_W'(1);
                end
            end
            ST_IDLE: if (resume) state_d = ST_RUN;
            default: ;
        endcase

        // A load overrides everything else on this edge, including an expiry.
        if (load) begin
            reload_d = load_val;
            count_d  = load_val;
            state_d  = ST_RUN;
            done_d   = 1'b0;
            tick_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_p) begin
            count_q  <= '0;
            reload_q <= RST_RELOAD;
            state_q  <= ST_IDLE;
            mode_q   <= 1'b0;
            done_q   <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            count_q  <= count_d;
            reload_q <= reload_d;
            state_q  <= state_d;
            mode_q   <= mode_d;
            done_q   <= done_d;
            tick_q   <= tick_d;
        end
    end

    assign count_o  = count_q;
    assign reload_o = reload_q;
    assign state_o  = state_q;
    assign mode_o   = mode_q;
    assign done_o   = done_q;
    assign tick_o   = tick_q;

endmodule

// File: rtl/vcu_timer_bank.sv
// Multi-channel countdown timer on the VCU register port; rdata bit 0 in status mode is "timer 0 expired".
module vcu_timer_bank
    import vcu_timer_pkg::*;
#(
    parameter int          NUM_CH         = 4,
    parameter int          CNT_W          = 28,
    parameter logic [31:0] DEFAULT_RELOAD = 32'h2FAF080,
    parameter logic [31:0] SIM_RELOAD     = 32'h10,
    parameter bit          IS_SIMULATION  = 1'b0
) (
    input  logic              clk,
    input  logic              reset_p,
    vcu_timer_bank_if.slave   vcu,
    output logic [NUM_CH-1:0] tick_o
);

    localparam logic [CNT_W-1:0] RST_RELOAD =
        IS_SIMULATION ? CNT_W'(SIM_RELOAD) : CNT_W'(DEFAULT_RELOAD);

    logic [31:0]      ctrl_q, ctrl_d, ctrl_eff;
    logic [SEL_W-1:0] sel_eff, sel_q;
    rsel_e            rsel;
    logic [31:0]      rdata;

    logic [NUM_CH-1:0]            load, pause, resume, set_mode, clr_done;
    logic [NUM_CH-1:0]            mode_a, done_a;
    logic [NUM_CH-1:0][CNT_W-1:0] count_a, reload_a;
    tmr_state_e                   state_a [NUM_CH];

    // A control write takes effect on the same edge, so decode uses the incoming word.
    always_comb begin
        ctrl_eff = vcu.vcu_reg_control_we ? vcu.vcu_reg_control : ctrl_q;
        ctrl_d   = ctrl_q;
        if (vcu.vcu_reg_control_we) begin
            ctrl_d          = vcu.vcu_reg_control;
            ctrl_d[CLR_BIT] = 1'b0;
        end
        sel_eff = ctrl_eff[SEL_MSB:SEL_LSB];
    end

    always_ff @(posedge clk) begin
        if (reset_p) ctrl_q <= '0;
        else         ctrl_q <= ctrl_d;
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic hit;
        assign hit         = (sel_eff == SEL_W'(g));
        assign load[g]     = vcu.vcu_reg_wdata_we & hit;
        assign set_mode[g] = vcu.vcu_reg_control_we & hit;
        assign pause[g]    = set_mode[g] & ~ctrl_eff[ENABLE_BIT];
        assign resume[g]   = set_mode[g] &  ctrl_eff[ENABLE_BIT];
        assign clr_done[g] = set_mode[g] &  ctrl_eff[CLR_BIT];

        vcu_timer_ch #(
            .CNT_W      (CNT_W),
            .RST_RELOAD (RST_RELOAD)
        ) u_ch (
            .clk      (clk),
            .reset_p  (reset_p),
            .load     (load[g]),
            .load_val (vcu.vcu_reg_wdata[CNT_W-1:0]),
            .pause    (pause[g]),
            .resume   (resume[g]),
            .set_mode (set_mode[g]),
            .mode_in  (ctrl_eff[PERIODIC_BIT]),
            .clr_done (clr_done[g]),
            .count_o  (count_a[g]),
            .reload_o (reload_a[g]),
            .state_o  (state_a[g]),
            .mode_o   (mode_a[g]),
            .done_o   (done_a[g]),
            .tick_o   (tick_o[g])
        );
    end

    // Out-of-range sel matches no channel, so per-channel reads fall through to zero.
    always_comb begin
        sel_q = ctrl_q[SEL_MSB:SEL_LSB];
        rsel  = rsel_e'(ctrl_q[RSEL_MSB:RSEL_LSB]);
        rdata = '0;
        if (rsel == RS_STATUS) rdata = 32'(done_a);
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel_q == SEL_W'(i)) begin
                case (rsel)
                    RS_COUNT:  rdata = 32'(count_a[i]);
                    RS_RELOAD: rdata = 32'(reload_a[i]);
                    RS_STATE:  rdata = {27'b0, mode_a[i], 2'b0, state_a[i]};
                    default:   ;
                endcase
            end
        end
    end

    assign vcu.vcu_reg_rdata = rdata;

    logic unused_bits;
    assign unused_bits = ^{ctrl_q, ctrl_eff, vcu.vcu_reg_wdata};

endmodule

// File: tb/tb_vcu_timer_bank.sv
// Self-checking bench for vcu_timer_bank: vector tables plus scripted periodic/pause sequences.
module tb_vcu_timer_bank;

    logic       clk = 1'b0;
    logic       reset_p;
    logic [3:0] tick_o;

    vcu_timer_bank_if bus ();

    vcu_timer_bank #(
        .NUM_CH         (4),
        .CNT_W          (28),
        .DEFAULT_RELOAD (32'h2FAF080),
        .SIM_RELOAD     (32'h10),
        .IS_SIMULATION  (1'b1)
    ) dut (
        .clk     (clk),
        .reset_p (reset_p),
        .vcu     (bus),
        .tick_o  (tick_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        cwe;
        logic [31:0] ctrl;
        logic        wwe;
        logic [31:0] wd;
        logic [3:0]  etick;
        logic [31:0] erd;
    } vec_t;

    typedef struct {
        int          id;
        logic [3:0]  etick;
        logic [31:0] erd;
    } exp_t;

    exp_t exp_q[$];
    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(input int r, input int c, input logic [31:0] cv,
                                input int w, input logic [31:0] wv,
                                input int et, input logic [31:0] er);
        vec_t v;
        v.rst   = 1'(r);
        v.cwe   = 1'(c);
        v.ctrl  = cv;
        v.wwe   = 1'(w);
        v.wd    = wv;
        v.etick = 4'(et);
        v.erd   = er;
        return v;
    endfunction

    task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got=%h want=%h", nm, id, act, exp);
        end
    endtask

    // Expectation is queued as the vector is driven, then popped once the edge has happened.
    task automatic step(input vec_t v, input int id);
        exp_t e;
        exp_t g;
        e.id    = id;
        e.etick = v.etick;
        e.erd   = v.erd;
        exp_q.push_back(e);
        reset_p                = v.rst;
        bus.vcu_reg_control_we = v.cwe;
        bus.vcu_reg_control    = v.ctrl;
        bus.vcu_reg_wdata_we   = v.wwe;
        bus.vcu_reg_wdata      = v.wd;
        @(posedge clk);
        #1;
        reset_p                = 1'b0;
        bus.vcu_reg_control_we = 1'b0;
        bus.vcu_reg_wdata_we   = 1'b0;
        g = exp_q.pop_front();
        chk("tick", g.id, 32'(tick_o), 32'(g.etick));
        chk("rdata", g.id, bus.vcu_reg_rdata, g.erd);
    endtask

    task automatic run_table(input int base);
        for (int i = 0; i < tbl.size(); i++) step(tbl[i], base + i);
        tbl.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        reset_p                = 1'b1;
        bus.vcu_reg_control    = '0;
        bus.vcu_reg_control_we = 1'b0;
        bus.vcu_reg_wdata      = '0;
        bus.vcu_reg_wdata_we   = 1'b0;

        // reset state, one-shot ch0, load 0, collisions on ch0
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 32'h2000, 0, 0, 0, 32'h10));
        tbl.push_back(mk(0, 1, 32'h1200, 1, 5, 0, 5));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 4));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 3));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 2));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 32'h3200, 0, 0, 0, 2));
        tbl.push_back(mk(0, 1, 32'h0200, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 1, 2, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 32'h1200, 1, 2, 0, 2));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 32'h0600, 0, 0, 1, 1));
        tbl.push_back(mk(0, 1, 32'h0600, 0, 0, 0, 0));
        run_table(0);

        // ch2 periodic reload 3: ticks every 4 edges, clear mid-stream, then pause
        for (int k = 0; k <= 25; k++) begin
            int et;
            int erd;
            int cwe;
            logic [31:0] cv;
            et  = (k > 0 && k % 4 == 0) ? 4 : 0;
            erd = (k >= 4 && k <= 20) || k >= 24 ? 4 : 0;
            cwe = (k == 0 || k == 21 || k == 25) ? 1 : 0;
            cv  = (k == 0) ? 32'h0302 : (k == 21) ? 32'h0702 : (k == 25) ? 32'h0002 : 32'h0;
            step(mk(0, cwe, cv, (k == 0) ? 1 : 0, 3, et, 32'(erd)), 100 + k);
        end

        // ch1 load 10, pause at count 6 for 20 cycles, resume, expire 7 edges later
        for (int k = 0; k <= 33; k++) begin
            int erd;
            int cwe;
            logic [31:0] cv;
            if (k <= 4)       erd = 10 - k;
            else if (k == 15) erd = 0;
            else if (k <= 26) erd = 6;
            else if (k <= 32) erd = 6 - (k - 26);
            else              erd = 0;
            cwe = (k == 0 || k == 5 || k == 15 || k == 16 || k == 26) ? 1 : 0;
            case (k)
                0, 26:   cv = 32'h1201;
                5, 16:   cv = 32'h1001;
                15:      cv = 32'h3001;
                default: cv = 32'h0;
            endcase
            step(mk(0, cwe, cv, (k == 0) ? 1 : 0, 10, (k == 33) ? 2 : 0, 32'(erd)), 200 + k);
        end

        // reset while ch0/ch3 run, then out-of-range sel
        tbl.push_back(mk(0, 1, 32'h1200, 1, 3, 0, 3));
        tbl.push_back(mk(0, 1, 32'h1203, 1, 3, 0, 3));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 2));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 32'h2000, 0, 0, 0, 32'h10));
        tbl.push_back(mk(0, 1, 32'h1003, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 32'h3003, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 32'h2003, 0, 0, 0, 32'h10));
        tbl.push_back(mk(0, 1, 32'h1205, 1, 7, 0, 0));
        tbl.push_back(mk(0, 1, 32'h2005, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 32'h3005, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 32'h0000, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        run_table(300);

        chk("sb_left", 999, 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
